// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_NOT  = 3'b011,
    OP_CLR  = 3'b100,
    OP_OR   = 3'b101,
    OP_AND  = 3'b110,
    OP_MUL  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // Bit positions inside the 4-bit {N, Z, C, V} flag word.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bus of the sequential ALU. The master issues operations
// and consumes results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic [3:0]       flags;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, flags
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, flags
  );
endinterface

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: result and {N,Z,C,V} for every opcode except
// MUL, which the sequencer computes with its shift-add multiplier.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           c;
  logic           v;

  // Opcode decode; C is the borrow for SUB, i.e. the inverted carry of A + ~B + 1.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_PASS: result = a;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = ~diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  result = ~a;
      OP_CLR:  result = '0;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
    flags         = '0;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one request in flight, single-cycle ops complete in one
// cycle, MUL runs a WIDTH-cycle LSB-first shift-add multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  alu_state_e         state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   alu_out_q, alu_out_d;
  logic [3:0]         flags_q, flags_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  alu_op_e          op;
  logic [WIDTH-1:0] comb_res;
  logic [3:0]       comb_flags;

  assign op = alu_op_e'(bus.ALU_Sel);

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a      (bus.A),
    .b      (bus.B),
    .op     (op),
    .result (comb_res),
    .flags  (comb_flags)
  );

  // Next-state, multiplier step and result capture.
  always_comb begin
    state_d  = state_q;
    alu_out_d = alu_out_q;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          if (op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            alu_out_d = comb_res;
            flags_d   = comb_flags;
            state_d   = ST_DONE;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          alu_out_d        = acc_d[WIDTH-1:0];
          flags_d          = '0;
          flags_d[FLAG_N]  = acc_d[WIDTH-1];
          flags_d[FLAG_Z]  = (acc_d[WIDTH-1:0] == '0);
          flags_d[FLAG_C]  = |acc_d[2*WIDTH-1:WIDTH];
          state_d          = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake outputs are registered decodes of the next state.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // All state; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ALU_Out   = alu_out_q;
  assign bus.flags     = flags_q;

endmodule
